// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central sequencing controller for the 5-stage MIPS pipeline.
// Chooses each cycle between advance, load-use stall, IF/ID flush and freeze.
// A req/ack handshake with a bounded wait covers multi-cycle data-memory accesses.
// It also keeps saturating counters of stall, flush and freeze cycles.
module pipe_hazard_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             exmem_memread_i,
    input  logic             exmem_memwrite_i,
    input  logic             dmem_ack_i,
    output logic             dmem_req_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_freeze_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] freeze_cnt_o,
    output logic [1:0]       state_o,
    output logic             err_o
);

    localparam int                WAIT_W     = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q, freeze_cnt_q;
    logic              memop;
    logic              load_use;
    logic              advance;
    logic              freeze_counted;

    assign memop    = exmem_memread_i | exmem_memwrite_i;
    assign load_use = idex_memread_i && (idex_rt_i != 5'd0) &&
                      ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

    // Freeze cycles in IDLE/HALT are idle time, not memory latency, so they are not counted
    assign freeze_counted = pipe_freeze_o && ((state_q == RUN) || (state_q == MEM_WAIT));

    assign state_o      = state_q;
    assign err_o        = err_q;
    assign stall_cnt_o  = stall_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;
    assign freeze_cnt_o = freeze_cnt_q;

    // Saturating increment shared by all three performance counters
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // State register, memory wait counter and sticky timeout flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Next state: an unacknowledged access parks in MEM_WAIT until ack or timeout
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = RUN;
            end
            RUN: begin
                if (memop && !dmem_ack_i) begin
                    state_d = MEM_WAIT;
                    wait_d  = WAIT_ONE;
                end else if (!start_i) begin
                    state_d = IDLE;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack_i) begin
                    state_d = start_i ? RUN : IDLE;
                    wait_d  = '0;
                end else if (wait_q == WAIT_LIMIT) begin
                    state_d = HALT;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    // Mealy outputs: freeze while memory is pending, otherwise stall > flush > advance
    always_comb begin
        dmem_req_o    = 1'b0;
        pipe_freeze_o = 1'b0;
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        advance       = 1'b0;
        case (state_q)
            RUN: begin
                dmem_req_o = memop;
                if (memop && !dmem_ack_i) pipe_freeze_o = 1'b1;
                else                      advance       = 1'b1;
            end
            MEM_WAIT: begin
                dmem_req_o = 1'b1;
                if (!dmem_ack_i) pipe_freeze_o = 1'b1;
                else             advance       = 1'b1;
            end
            default: begin
                pipe_freeze_o = 1'b1;
            end
        endcase
        if (advance) begin
            if (load_use) begin
                idex_bubble_o = 1'b1;
            end else begin
                pc_write_o   = 1'b1;
                ifid_write_o = 1'b1;
                ifid_flush_o = branch_taken_i | jump_i;
            end
        end
    end

    // Performance counters, one step per qualifying cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            if (idex_bubble_o)  stall_cnt_q  <= sat_inc(stall_cnt_q);
            if (ifid_flush_o)   flush_cnt_q  <= sat_inc(flush_cnt_q);
            if (freeze_counted) freeze_cnt_q <= sat_inc(freeze_cnt_q);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios plus randomized run against a rule-level model.
module tb_pipe_hazard_ctrl;

    localparam int     CNT_W   = 8;
    localparam int     TIMEOUT = 4;
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [4:0]       ifid_rs_i;
    logic [4:0]       ifid_rt_i;
    logic             idex_memread_i;
    logic [4:0]       idex_rt_i;
    logic             branch_taken_i;
    logic             jump_i;
    logic             exmem_memread_i;
    logic             exmem_memwrite_i;
    logic             dmem_ack_i;
    logic             dmem_req_o;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             pipe_freeze_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic [CNT_W-1:0] freeze_cnt_o;
    logic [1:0]       state_o;
    logic             err_o;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state (states as plain integers 0..3)
    int     m_state;
    int     m_wait;
    logic   m_err;
    longint m_stall, m_flush, m_freeze;
    logic   e_req, e_pcw, e_ifw, e_flush, e_bub, e_frz;
    bit     pending = 1'b0;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .ifid_rs_i        (ifid_rs_i),
        .ifid_rt_i        (ifid_rt_i),
        .idex_memread_i   (idex_memread_i),
        .idex_rt_i        (idex_rt_i),
        .branch_taken_i   (branch_taken_i),
        .jump_i           (jump_i),
        .exmem_memread_i  (exmem_memread_i),
        .exmem_memwrite_i (exmem_memwrite_i),
        .dmem_ack_i       (dmem_ack_i),
        .dmem_req_o       (dmem_req_o),
        .pc_write_o       (pc_write_o),
        .ifid_write_o     (ifid_write_o),
        .ifid_flush_o     (ifid_flush_o),
        .idex_bubble_o    (idex_bubble_o),
        .pipe_freeze_o    (pipe_freeze_o),
        .stall_cnt_o      (stall_cnt_o),
        .flush_cnt_o      (flush_cnt_o),
        .freeze_cnt_o     (freeze_cnt_o),
        .state_o          (state_o),
        .err_o            (err_o)
    );

    initial forever #5 clk_i = ~clk_i;

    function automatic longint bump(input longint v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_wait = 0; m_err = 1'b0;
        m_stall = 0; m_flush = 0; m_freeze = 0;
    endtask

    // Expected combinational outputs for the current state and inputs
    task automatic model_comb();
        logic memop, hazard, frozen;
        memop  = exmem_memread_i | exmem_memwrite_i;
        hazard = idex_memread_i && (idex_rt_i != 5'd0) &&
                 ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
        frozen = (m_state == 0) || (m_state == 3) ||
                 (m_state == 1 && memop && !dmem_ack_i) || (m_state == 2 && !dmem_ack_i);
        e_req   = (m_state == 1 && memop) || (m_state == 2);
        e_frz   = frozen;
        e_bub   = !frozen && hazard;
        e_pcw   = !frozen && !hazard;
        e_ifw   = e_pcw;
        e_flush = e_pcw && (branch_taken_i || jump_i);
    endtask

    // Effect of one rising clock edge on the model
    task automatic model_clock();
        logic memop;
        memop = exmem_memread_i | exmem_memwrite_i;
        if (e_bub) m_stall = bump(m_stall);
        if (e_flush) m_flush = bump(m_flush);
        if (e_frz && (m_state == 1 || m_state == 2)) m_freeze = bump(m_freeze);
        case (m_state)
            0: if (start_i) m_state = 1;
            1: begin
                if (memop && !dmem_ack_i) begin m_state = 2; m_wait = 1; end
                else if (!start_i) m_state = 0;
            end
            2: begin
                if (dmem_ack_i) m_state = start_i ? 1 : 0;
                else if (m_wait >= TIMEOUT) begin m_state = 3; m_err = 1'b1; end
                else m_wait = m_wait + 1;
            end
            default: ;
        endcase
    endtask

    task automatic clear_inputs();
        ifid_rs_i = 5'd0; ifid_rt_i = 5'd0; idex_memread_i = 1'b0; idex_rt_i = 5'd0;
        branch_taken_i = 1'b0; jump_i = 1'b0; exmem_memread_i = 1'b0;
        exmem_memwrite_i = 1'b0; dmem_ack_i = 1'b0;
    endtask

    // Move to the next falling edge, commit the model edge, clear per-cycle inputs
    task automatic next_cycle();
        @(negedge clk_i);
        if (pending) model_clock();
        pending = 1'b0;
        clear_inputs();
    endtask

    task automatic settle();
        #1;
        model_comb();
        pending = 1'b1;
    endtask

    task automatic apply_reset();
        rst_i = 1'b1; start_i = 1'b0;
        clear_inputs();
        model_reset();
        pending = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic enter_run();
        next_cycle(); start_i = 1'b1; settle();
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b0; clear_inputs();
        #1;
        tests_run++; if (state_o !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_state: got %0d expected 0", state_o); end
        tests_run++; if ({err_o, pipe_freeze_o, pc_write_o, dmem_req_o} !== 4'b0100) begin tests_failed++; $display("[TB] FAIL reset_outputs err/frz/pcw/req: got %b expected 0100", {err_o, pipe_freeze_o, pc_write_o, dmem_req_o}); end
        tests_run++; if ({stall_cnt_o, flush_cnt_o, freeze_cnt_o} !== '0) begin tests_failed++; $display("[TB] FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", stall_cnt_o, flush_cnt_o, freeze_cnt_o); end
        apply_reset();
    endtask

    task automatic test_run_plain();
        logic [1:0] exp_state;
        logic       exp_pcw;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            next_cycle(); start_i = 1'b1; settle();
            exp_state = (i == 0) ? 2'd0 : 2'd1;
            exp_pcw   = (i == 0) ? 1'b0 : 1'b1;
            tests_run++; if (state_o !== exp_state) begin tests_failed++; $display("[TB] FAIL run_state cyc%0d: got %0d expected %0d", i, state_o, exp_state); end
            tests_run++; if (pc_write_o !== exp_pcw) begin tests_failed++; $display("[TB] FAIL run_pc_write cyc%0d: got %0d expected %0d", i, pc_write_o, exp_pcw); end
        end
        tests_run++; if ({stall_cnt_o, flush_cnt_o, freeze_cnt_o} !== '0) begin tests_failed++; $display("[TB] FAIL run_counters: got %0d/%0d/%0d expected 0/0/0", stall_cnt_o, flush_cnt_o, freeze_cnt_o); end
    endtask

    task automatic test_load_use();
        apply_reset(); enter_run();
        next_cycle(); idex_memread_i = 1'b1; idex_rt_i = 5'd8; ifid_rs_i = 5'd8; ifid_rt_i = 5'd3; settle();
        tests_run++; if ({pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o} !== 4'b0010) begin tests_failed++; $display("[TB] FAIL loaduse_rs pcw/ifw/bub/flush: got %b expected 0010", {pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o}); end
        next_cycle(); idex_memread_i = 1'b1; settle();
        tests_run++; if (stall_cnt_o !== 8'd1) begin tests_failed++; $display("[TB] FAIL loaduse_cnt1: got %0d expected 1", stall_cnt_o); end
        tests_run++; if ({pc_write_o, idex_bubble_o} !== 2'b10) begin tests_failed++; $display("[TB] FAIL loaduse_r0 pcw/bub: got %b expected 10", {pc_write_o, idex_bubble_o}); end
        next_cycle(); idex_memread_i = 1'b1; idex_rt_i = 5'd5; ifid_rs_i = 5'd2; ifid_rt_i = 5'd5; settle();
        tests_run++; if (idex_bubble_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL loaduse_rt bub: got %0d expected 1", idex_bubble_o); end
        next_cycle(); idex_rt_i = 5'd5; ifid_rs_i = 5'd5; settle();
        tests_run++; if ({stall_cnt_o, idex_bubble_o} !== {8'd2, 1'b0}) begin tests_failed++; $display("[TB] FAIL loaduse_noread cnt/bub: got %0d/%0d expected 2/0", stall_cnt_o, idex_bubble_o); end
        next_cycle(); settle();
        tests_run++; if (stall_cnt_o !== 8'd2) begin tests_failed++; $display("[TB] FAIL loaduse_cnt2: got %0d expected 2", stall_cnt_o); end
    endtask

    task automatic test_hazard_vs_jump();
        apply_reset(); enter_run();
        next_cycle(); idex_memread_i = 1'b1; idex_rt_i = 5'd9; ifid_rs_i = 5'd9; jump_i = 1'b1; settle();
        tests_run++; if ({pc_write_o, idex_bubble_o, ifid_flush_o} !== 3'b010) begin tests_failed++; $display("[TB] FAIL hzjump pcw/bub/flush: got %b expected 010", {pc_write_o, idex_bubble_o, ifid_flush_o}); end
        next_cycle(); jump_i = 1'b1; settle();
        tests_run++; if ({pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o} !== 4'b1110) begin tests_failed++; $display("[TB] FAIL jump pcw/ifw/flush/bub: got %b expected 1110", {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o}); end
        tests_run++; if ({stall_cnt_o, flush_cnt_o} !== {8'd1, 8'd0}) begin tests_failed++; $display("[TB] FAIL hzjump_cnts stall/flush: got %0d/%0d expected 1/0", stall_cnt_o, flush_cnt_o); end
        next_cycle(); branch_taken_i = 1'b1; settle();
        tests_run++; if ({ifid_flush_o, flush_cnt_o} !== {1'b1, 8'd1}) begin tests_failed++; $display("[TB] FAIL branch flush/cnt: got %0d/%0d expected 1/1", ifid_flush_o, flush_cnt_o); end
        next_cycle(); settle();
        tests_run++; if ({ifid_flush_o, flush_cnt_o} !== {1'b0, 8'd2}) begin tests_failed++; $display("[TB] FAIL after_branch flush/cnt: got %0d/%0d expected 0/2", ifid_flush_o, flush_cnt_o); end
    endtask

    task automatic test_mem_wait();
        logic [1:0] exp_state;
        apply_reset(); enter_run();
        for (int i = 0; i < 4; i++) begin
            next_cycle(); exmem_memread_i = 1'b1; dmem_ack_i = (i == 3); settle();
            exp_state = (i == 0) ? 2'd1 : 2'd2;
            tests_run++; if (state_o !== exp_state) begin tests_failed++; $display("[TB] FAIL memwait_state cyc%0d: got %0d expected %0d", i, state_o, exp_state); end
            tests_run++; if ({dmem_req_o, pipe_freeze_o, pc_write_o} !== {1'b1, (i != 3), (i == 3)}) begin tests_failed++; $display("[TB] FAIL memwait req/frz/pcw cyc%0d: got %b expected %b", i, {dmem_req_o, pipe_freeze_o, pc_write_o}, {1'b1, (i != 3), (i == 3)}); end
        end
        next_cycle(); settle();
        tests_run++; if ({state_o, dmem_req_o, freeze_cnt_o} !== {2'd1, 1'b0, 8'd3}) begin tests_failed++; $display("[TB] FAIL memwait_done state/req/frzcnt: got %0d/%0d/%0d expected 1/0/3", state_o, dmem_req_o, freeze_cnt_o); end
        next_cycle(); exmem_memread_i = 1'b1; dmem_ack_i = 1'b1; settle();
        tests_run++; if ({dmem_req_o, pipe_freeze_o} !== 2'b10) begin tests_failed++; $display("[TB] FAIL zerowait req/frz: got %b expected 10", {dmem_req_o, pipe_freeze_o}); end
        next_cycle(); settle();
        tests_run++; if ({state_o, freeze_cnt_o} !== {2'd1, 8'd3}) begin tests_failed++; $display("[TB] FAIL zerowait state/frzcnt: got %0d/%0d expected 1/3", state_o, freeze_cnt_o); end
    endtask

    task automatic test_timeout();
        apply_reset(); enter_run();
        for (int i = 0; i < TIMEOUT + 1; i++) begin
            next_cycle(); exmem_memwrite_i = 1'b1; settle();
            tests_run++; if (state_o !== ((i == 0) ? 2'd1 : 2'd2)) begin tests_failed++; $display("[TB] FAIL timeout_wait_state cyc%0d: got %0d expected %0d", i, state_o, (i == 0) ? 1 : 2); end
        end
        next_cycle(); settle();
        tests_run++; if ({state_o, err_o, pipe_freeze_o, dmem_req_o} !== {2'd3, 1'b1, 1'b1, 1'b0}) begin tests_failed++; $display("[TB] FAIL halt state/err/frz/req: got %0d/%0d/%0d/%0d expected 3/1/1/0", state_o, err_o, pipe_freeze_o, dmem_req_o); end
        tests_run++; if (freeze_cnt_o !== 8'(TIMEOUT + 1)) begin tests_failed++; $display("[TB] FAIL halt_frzcnt: got %0d expected %0d", freeze_cnt_o, TIMEOUT + 1); end
        for (int i = 0; i < 3; i++) begin
            next_cycle(); start_i = 1'b1; exmem_memwrite_i = 1'b1; dmem_ack_i = 1'b1; settle();
            tests_run++; if ({state_o, pipe_freeze_o, pc_write_o} !== {2'd3, 1'b1, 1'b0}) begin tests_failed++; $display("[TB] FAIL halt_sticky cyc%0d state/frz/pcw: got %0d/%0d/%0d expected 3/1/0", i, state_o, pipe_freeze_o, pc_write_o); end
        end
        rst_i = 1'b1;
        #1;
        tests_run++; if ({state_o, err_o} !== {2'd0, 1'b0}) begin tests_failed++; $display("[TB] FAIL halt_reset state/err: got %0d/%0d expected 0/0", state_o, err_o); end
        apply_reset();
    endtask

    task automatic test_reset_and_stop_in_wait();
        apply_reset(); enter_run();
        next_cycle(); exmem_memread_i = 1'b1; settle();
        next_cycle(); exmem_memread_i = 1'b1; settle();
        tests_run++; if ({state_o, dmem_req_o} !== {2'd2, 1'b1}) begin tests_failed++; $display("[TB] FAIL midwait state/req: got %0d/%0d expected 2/1", state_o, dmem_req_o); end
        #2 rst_i = 1'b1;
        #1;
        tests_run++; if ({state_o, dmem_req_o, pipe_freeze_o, freeze_cnt_o} !== {2'd0, 1'b0, 1'b1, 8'd0}) begin tests_failed++; $display("[TB] FAIL async_reset state/req/frz/frzcnt: got %0d/%0d/%0d/%0d expected 0/0/1/0", state_o, dmem_req_o, pipe_freeze_o, freeze_cnt_o); end
        apply_reset(); enter_run();
        next_cycle(); exmem_memread_i = 1'b1; settle();
        next_cycle(); start_i = 1'b0; exmem_memread_i = 1'b1; settle();
        tests_run++; if ({state_o, dmem_req_o} !== {2'd2, 1'b1}) begin tests_failed++; $display("[TB] FAIL stop_wait state/req: got %0d/%0d expected 2/1", state_o, dmem_req_o); end
        next_cycle(); exmem_memread_i = 1'b1; dmem_ack_i = 1'b1; settle();
        tests_run++; if ({state_o, pipe_freeze_o} !== {2'd2, 1'b0}) begin tests_failed++; $display("[TB] FAIL stop_ack state/frz: got %0d/%0d expected 2/0", state_o, pipe_freeze_o); end
        next_cycle(); settle();
        tests_run++; if (state_o !== 2'd0) begin tests_failed++; $display("[TB] FAIL stop_idle: got %0d expected 0", state_o); end
        next_cycle(); settle();
        tests_run++; if (state_o !== 2'd0) begin tests_failed++; $display("[TB] FAIL stop_idle_hold: got %0d expected 0", state_o); end
    endtask

    task automatic test_saturation();
        apply_reset(); enter_run();
        for (int i = 0; i < int'(CNT_MAX) + 5; i++) begin
            next_cycle(); idex_memread_i = 1'b1; idex_rt_i = 5'd4; ifid_rt_i = 5'd4; settle();
        end
        next_cycle(); settle();
        tests_run++; if (stall_cnt_o !== CNT_MAX[CNT_W-1:0]) begin tests_failed++; $display("[TB] FAIL stall_saturate: got %0d expected %0d", stall_cnt_o, CNT_MAX); end
    endtask

    task automatic test_random();
        logic [5:0] exp_ctl;
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) apply_reset();
            next_cycle();
            start_i          = ($urandom_range(0, 9) != 0);
            ifid_rs_i        = 5'($urandom_range(0, 3));
            ifid_rt_i        = 5'($urandom_range(0, 3));
            idex_rt_i        = 5'($urandom_range(0, 3));
            idex_memread_i   = ($urandom_range(0, 2) == 0);
            branch_taken_i   = ($urandom_range(0, 4) == 0);
            jump_i           = ($urandom_range(0, 5) == 0);
            exmem_memread_i  = ($urandom_range(0, 3) == 0);
            exmem_memwrite_i = ($urandom_range(0, 4) == 0);
            dmem_ack_i       = ($urandom_range(0, 1) == 0);
            settle();
            exp_ctl = {e_req, e_pcw, e_ifw, e_flush, e_bub, e_frz};
            tests_run++; if ({dmem_req_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o} !== exp_ctl) begin tests_failed++; $display("[TB] FAIL rand_ctl cyc%0d req/pcw/ifw/flush/bub/frz: got %b expected %b", i, {dmem_req_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o}, exp_ctl); end
            tests_run++; if (state_o !== m_state[1:0]) begin tests_failed++; $display("[TB] FAIL rand_state cyc%0d: got %0d expected %0d", i, state_o, m_state); end
            tests_run++; if (err_o !== m_err) begin tests_failed++; $display("[TB] FAIL rand_err cyc%0d: got %0d expected %0d", i, err_o, m_err); end
            tests_run++; if (stall_cnt_o !== m_stall[CNT_W-1:0]) begin tests_failed++; $display("[TB] FAIL rand_stall cyc%0d: got %0d expected %0d", i, stall_cnt_o, m_stall); end
            tests_run++; if (flush_cnt_o !== m_flush[CNT_W-1:0]) begin tests_failed++; $display("[TB] FAIL rand_flush cyc%0d: got %0d expected %0d", i, flush_cnt_o, m_flush); end
            tests_run++; if (freeze_cnt_o !== m_freeze[CNT_W-1:0]) begin tests_failed++; $display("[TB] FAIL rand_freeze cyc%0d: got %0d expected %0d", i, freeze_cnt_o, m_freeze); end
        end
    endtask

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0;
        clear_inputs();
        model_reset();
        test_reset();
        test_run_plain();
        test_load_use();
        test_hazard_vs_jump();
        test_mem_wait();
        test_timeout();
        test_reset_and_stop_in_wait();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencing controller for the 5-stage MIPS pipeline. It decides every cycle whether to advance, stall, flush or freeze the pipeline. It covers load-use stalls, branch/jump flushes in ID, and multi-cycle data-memory accesses through a req/ack handshake with timeout. It also keeps the stall, flush and freeze counters that the bench samples.

Parameters:
CNT_W, 32, width of each performance counter
TIMEOUT, 16, max MEM_WAIT cycles without ack before HALT (>=2)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
start_i  in  1  pipeline run enable
ifid_rs_i  in  5  rs field of instruction in IF/ID
ifid_rt_i  in  5  rt field of instruction in IF/ID
idex_memread_i  in  1  ID/EX instruction is a load
idex_rt_i  in  5  destination rt of ID/EX load
branch_taken_i  in  1  resolved taken beq in ID
jump_i  in  1  j in ID
exmem_memread_i  in  1  EX/MEM instruction reads data memory
exmem_memwrite_i  in  1  EX/MEM instruction writes data memory
dmem_ack_i  in  1  data memory completes access this cycle
dmem_req_o  out  1  data memory access request
pc_write_o  out  1  PC load enable
ifid_write_o  out  1  IF/ID load enable
ifid_flush_o  out  1  clear IF/ID to nop
idex_bubble_o  out  1  force ID/EX control fields to zero
pipe_freeze_o  out  1  hold ID/EX, EX/MEM, MEM/WB and suppress RegWrite/MemWrite
stall_cnt_o  out  CNT_W  load-use stall cycles
flush_cnt_o  out  CNT_W  flush cycles
freeze_cnt_o  out  CNT_W  memory freeze cycles
state_o  out  2  IDLE=0, RUN=1, MEM_WAIT=2, HALT=3
err_o  out  1  sticky memory timeout flag

Behaviour:
- The state register, counters, wait counter and err_o update on the clock, with async reset. All other outputs are combinational from state and inputs (Mealy).
- Reset: state IDLE, counters 0, wait counter 0, err_o 0.
- In IDLE and HALT: pipe_freeze_o=1, pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=0, dmem_req_o=0.
- Transitions:
  - IDLE->RUN when start_i=1.
  - HALT is left only by rst_i.
- memop = exmem_memread_i | exmem_memwrite_i.
- RUN:
  - dmem_req_o = memop.
  - If memop and !dmem_ack_i: freeze cycle, next state MEM_WAIT, wait counter := 1.
  - If memop and dmem_ack_i (zero-wait): no freeze.
  - Else if start_i=0: next state IDLE. The current cycle still advances normally.
- MEM_WAIT:
  - dmem_req_o=1. pipe_freeze_o = !dmem_ack_i.
  - On ack: next state RUN if start_i else IDLE; the pipeline advances on that edge, so the same op is never re-requested.
  - No ack: wait counter +1. If the wait counter equals TIMEOUT, next state HALT and err_o := 1.
- Freeze cycle outputs: pipe_freeze_o=1, pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=0.
- Non-freeze RUN/ack cycle, in strict priority order:
  1. Load-use hazard: idex_memread_i && idex_rt_i!=0 && (idex_rt_i==ifid_rs_i || idex_rt_i==ifid_rt_i). Outputs pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0. A concurrent branch_taken_i/jump_i is ignored this cycle and re-evaluated next cycle.
  2. branch_taken_i | jump_i: pc_write_o=1, ifid_write_o=1, ifid_flush_o=1.
  3. Otherwise: pc_write_o=1, ifid_write_o=1, all else 0.
- Counters:
  - stall_cnt +1 per cycle with idex_bubble_o=1.
  - flush_cnt +1 per cycle with ifid_flush_o=1.
  - freeze_cnt +1 per cycle with pipe_freeze_o=1 in RUN or MEM_WAIT (not IDLE/HALT).
  - All counters saturate at all-ones.
- rst_i mid-MEM_WAIT: immediate return to IDLE, dmem_req_o drops asynchronously, counters cleared.
- start_i dropped in MEM_WAIT: the access completes first, then IDLE.

Test Plan:
1. Reset, start_i=1, no hazards/memops for 10 cycles -> state_o=1 from cycle 1, pc_write_o=1 every cycle, all counters 0.
2. idex_memread_i=1, idex_rt_i=8, ifid_rs_i=8 for one cycle -> pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, stall_cnt_o=1. Repeat with idex_rt_i=0 -> no stall.
3. Load-use hazard plus jump_i same cycle -> stall only, flush_cnt unchanged. Next cycle hazard cleared, jump_i=1 -> ifid_flush_o=1, flush_cnt_o=1.
4. exmem_memread_i=1, dmem_ack_i asserted after 3 cycles -> dmem_req_o=1 for 4 cycles, pipe_freeze_o=1 for 3 cycles, freeze_cnt_o=3, state_o 1->2->2->2->1. With ack in the same cycle -> freeze_cnt unchanged.
5. TIMEOUT=4, memwrite with ack never asserted -> HALT (state_o=3), err_o=1, pipe_freeze_o=1 persistently; only rst_i returns to IDLE with err_o=0.
6. rst_i pulsed mid-MEM_WAIT -> outputs reach reset values before the next clock edge; start_i low in MEM_WAIT, then ack -> state_o=0.
